text_ram_ctl: RTL and testbench
===============================

Name: text_ram_ctl

Overview:
- Parametrised single-clock simple-dual-port text/character RAM; successor to the fixed 16x3072 text buffer.
- Adds:
  - configurable width, depth and output pipelining
  - byte write enables
  - out-of-range protection
  - hardware fill/clear engine with busy flag
- Sits between the CPU bus write path and the video/text scan-out read path.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 12, address width in bits.
- DEPTH, 3072, number of valid words; must satisfy DEPTH <= 2**ADDR_W. Need not be a power of two.
- OUT_REG, 1, 1 = extra output register stage (2-cycle read latency); 0 = 1-cycle read latency.
- CLEAR_ON_RESET, 1, 1 = fill the whole memory with zero after reset release.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read word address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  one-cycle pulse marking rd_data valid for a request.
- clr_req  in  1  start a fill sweep, sampled in IDLE only.
- clr_data  in  DATA_W  fill value, latched when clr_req is accepted.
- busy  out  1  high while the fill engine owns the write port.

Behaviour:
- Interface (already decided): one clock, clk; reset resetn is synchronous and active-low. Nothing is asynchronous.

Reset (resetn=0 at a clk edge):
- rd_data=0, rd_valid=0, read pipeline flushed.
- Fill pointer set to 0.
- If CLEAR_ON_RESET=1: state=CLEAR, fill value=0, busy=1.
- If CLEAR_ON_RESET=0: state=IDLE, busy=0.
- Memory array is not otherwise touched by reset.
- A reset asserted mid-sweep restarts the sweep from address 0.

Write path:
- When wr_en=1 and state=IDLE and wr_addr<DEPTH, write the bytes selected by wr_be.
- wr_be=0 writes nothing.
- wr_addr>=DEPTH: write dropped silently.
- wr_en while busy=1: dropped silently; no queueing.

Read path:
- Each rd_en=1 cycle is one request. Back-to-back reads give one result per cycle.
- Latency from the rd_en edge to rd_valid/rd_data: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
- rd_addr>=DEPTH: returns 0 with rd_valid still asserted.
- Read and write to the same address in the same cycle: returns the OLD contents (read-before-write).
- rd_data holds its last value when rd_valid=0.
- Reads are serviced during CLEAR and return current array contents, i.e. partly filled.

Fill engine FSM, two states:
- IDLE:
  - clr_req=1 latches clr_data and sets pointer to 0.
  - Next state CLEAR; busy=1 from the next cycle.
- CLEAR:
  - Each cycle writes the fill value to mem[pointer] with all bytes enabled, then pointer+1.
  - The cycle writing pointer=DEPTH-1 returns the FSM to IDLE; busy=0 the following cycle.
  - One sweep takes exactly DEPTH busy cycles.
  - clr_req during CLEAR is ignored.
- Pointer is ADDR_W bits and never addresses >=DEPTH.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=3072, then release -> busy high for exactly 3072 cycles; afterwards reading addresses 0, 1535 and 3071 returns 0x0000 with rd_valid 2 cycles after rd_en (OUT_REG=1).
- Write 0xABCD to address 5 with wr_be=2'b11, then wr_data=0x1234 with wr_be=2'b01 -> read of address 5 returns 0xAB34; with OUT_REG=0 latency is 1 cycle.
- Write 0x4142 to address 3072, then read address 3072 -> array unchanged; rd_data=0x0000 with rd_valid=1. Read address 3071 is unaffected.
- Same-cycle write of 0x5555 and read at address 10, where mem[10] already holds 0x1111 -> read returns 0x1111; next read returns 0x5555.
- clr_req with clr_data=0x0020, wr_en pulses to address 7 during busy, and a second clr_req mid-sweep -> writes dropped; sweep finishes in DEPTH cycles; all reads return 0x0020.
- Assert resetn=0 halfway through a sweep with fill value 0x0020 -> sweep restarts at address 0 with fill value 0 and busy high for a full DEPTH cycles after release.

Source files
------------

// File: rtl/text_ram_ctl.sv
// Simple-dual-port text RAM with byte enables and bounds checks.
// A fill engine sweeps the array and owns the write port while busy.
module text_ram_ctl #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 12,
  parameter int DEPTH          = 3072,
  parameter int OUT_REG        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                clr_req,
  input  logic [DATA_W-1:0]   clr_data,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] fill_q, fill_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;

  logic              wr_in_range;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_word;

  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_X;
  assign busy        = (state_q == CLEAR);

  // The sweep takes the write port; CPU writes are simply dropped.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    fill_d    = fill_q;
    mem_we    = 1'b0;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    mem_be    = wr_be;
    unique case (state_q)
      IDLE: begin
        mem_we = wr_en && wr_in_range;
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
          fill_d  = clr_data;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = fill_q;
        mem_be    = '1;
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn && mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign rd_word = rd_in_range ? mem[rd_addr] : '0;

  always_comb begin
    s1_vld_d  = rd_en;
    s1_data_d = s1_data_q;
    if (rd_en) s1_data_d = rd_word;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      ptr_q     <= '0;
      fill_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      fill_q    <= fill_d;
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_vld_d  = s1_vld_q;
      s2_data_d = s2_data_q;
      if (s1_vld_q) s2_data_d = s1_data_q;
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        s2_vld_q  <= 1'b0;
        s2_data_q <= '0;
      end else begin
        s2_vld_q  <= s2_vld_d;
        s2_data_q <= s2_data_d;
      end
    end

    assign rd_valid = s2_vld_q;
    assign rd_data  = s2_data_q;
  end else begin : g_noreg
    assign rd_valid = s1_vld_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: tb/tb_text_ram_ctl.sv
// Bench for text_ram_ctl: two instances (default, and small/unregistered)
// against a countdown/array reference model plus literal checks.
module tb_text_ram_ctl;

  localparam int DEP [2] = '{3072, 20};
  localparam int LAT [2] = '{2, 1};
  localparam int COR [2] = '{1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn  = 1'b0;
  logic        wr_en   = 1'b0;
  logic        rd_en   = 1'b0;
  logic        clr_req = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [11:0] rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] clr_data = '0;
  logic [1:0]  wr_be   = '0;

  logic [15:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, busy0, busy1;

  text_ram_ctl u0 (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0),
    .clr_req(clr_req), .clr_data(clr_data), .busy(busy0)
  );

  text_ram_ctl #(
    .DATA_W(16), .ADDR_W(5), .DEPTH(20), .OUT_REG(0), .CLEAR_ON_RESET(0)
  ) u1 (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_addr(wr_addr[4:0]), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr[4:0]),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .clr_req(clr_req), .clr_data(clr_data), .busy(busy1)
  );

  // Reference model state
  logic [15:0] mm [2][4096];
  bit          kn [2][4096];
  int          left [2];
  int          ptr  [2];
  logic [15:0] fill [2];
  bit          pv [2][4];
  logic [15:0] pd [2][4];
  bit          pk [2][4];
  bit          ev [2];
  logic [15:0] ed [2];
  bit          ek [2];
  longint      ncyc = 0;
  bit          chk_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_step(int k);
    int wa, ra, s;
    wa = (k == 0) ? int'(wr_addr) : int'(wr_addr[4:0]);
    ra = (k == 0) ? int'(rd_addr) : int'(rd_addr[4:0]);
    if (!resetn) begin
      for (int i = 0; i < 4; i++) pv[k][i] = 1'b0;
      ev[k]   = 1'b0;
      ed[k]   = '0;
      ek[k]   = 1'b1;
      left[k] = (COR[k] != 0) ? DEP[k] : 0;
      ptr[k]  = 0;
      fill[k] = '0;
    end else begin
      if (rd_en) begin
        s = int'((ncyc + longint'(LAT[k]) - 1) % 4);
        pv[k][s] = 1'b1;
        pd[k][s] = (ra < DEP[k]) ? mm[k][ra] : 16'h0000;
        pk[k][s] = (ra < DEP[k]) ? kn[k][ra] : 1'b1;
      end
      s = int'(ncyc % 4);
      ev[k] = pv[k][s];
      if (pv[k][s]) begin
        ed[k] = pd[k][s];
        ek[k] = pk[k][s];
        pv[k][s] = 1'b0;
      end
      if (left[k] > 0) begin
        mm[k][ptr[k]] = fill[k];
        kn[k][ptr[k]] = 1'b1;
        ptr[k]++;
        left[k]--;
      end else begin
        if (wr_en && wa < DEP[k]) begin
          for (int b = 0; b < 2; b++)
            if (wr_be[b]) mm[k][wa][8*b +: 8] = wr_data[8*b +: 8];
          if (wr_be == 2'b11) kn[k][wa] = 1'b1;
        end
        if (clr_req) begin
          fill[k] = clr_data;
          ptr[k]  = 0;
          left[k] = DEP[k];
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    ncyc++;
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy0", 32'(busy0), 32'(left[0] > 0));
      cmp("rd_valid0", 32'(rd_valid0), 32'(ev[0]));
      if (ek[0]) cmp("rd_data0", 32'(rd_data0), 32'(ed[0]));
      cmp("busy1", 32'(busy1), 32'(left[1] > 0));
      cmp("rd_valid1", 32'(rd_valid1), 32'(ev[1]));
      if (ek[1]) cmp("rd_data1", 32'(rd_data1), 32'(ed[1]));
    end
  end

  task automatic do_write(input logic [11:0] a, input logic [15:0] d,
                          input logic [1:0] be);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, input string nm,
                         input logic [15:0] x0, input bit wr_too,
                         input logic [15:0] wd);
    int l0, l1;
    logic [15:0] d0;
    l0 = 0; l1 = 0; d0 = '0;
    @(negedge clk);
    rd_en = 1'b1; rd_addr = a;
    if (wr_too) begin
      wr_en = 1'b1; wr_addr = a; wr_data = wd; wr_be = 2'b11;
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      if (rd_valid0 && l0 == 0) begin l0 = k; d0 = rd_data0; end
      if (rd_valid1 && l1 == 0) l1 = k;
    end
    cmp({nm, " data"}, 32'(d0), 32'(x0));
    cmp({nm, " lat0"}, 32'(l0), 32'd2);
    cmp({nm, " lat1"}, 32'(l1), 32'd1);
  endtask

  task automatic do_reset;
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Counts busy0-high cycles from the current falling edge; mode 1 also
  // pokes a write and a second clr_req into the sweep.
  task automatic count_busy(input int mode, output int n);
    n = 0;
    while (busy0 && n < 5000) begin
      n++;
      @(negedge clk);
      clr_req = 1'b0;
      wr_en   = 1'b0;
      if (mode == 1 && n == 100) begin
        wr_en = 1'b1; wr_addr = 12'd7; wr_data = 16'hDEAD; wr_be = 2'b11;
      end
      if (mode == 1 && n == 1000) begin
        clr_req = 1'b1; clr_data = 16'h0099;
      end
    end
  endtask

  int nb;

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    cmp("reset rd_valid", 32'(rd_valid0), 32'd0);
    cmp("reset rd_data", 32'(rd_data0), 32'd0);
    cmp("reset busy0", 32'(busy0), 32'd1);
    cmp("reset busy1", 32'(busy1), 32'd0);

    @(negedge clk);
    resetn = 1'b1; clr_req = 1'b1; clr_data = 16'h0000;
    count_busy(0, nb);
    cmp("por busy cycles", 32'(nb), 32'd3072);

    do_read(12'd0,    "rd0",    16'h0000, 1'b0, 16'h0);
    do_read(12'd1535, "rd1535", 16'h0000, 1'b0, 16'h0);
    do_read(12'd3071, "rd3071", 16'h0000, 1'b0, 16'h0);

    do_write(12'd5, 16'hABCD, 2'b11);
    do_write(12'd5, 16'h1234, 2'b01);
    do_read(12'd5, "byte we", 16'hAB34, 1'b0, 16'h0);
    cmp("model mem5", 32'(mm[0][5]), 32'h0000AB34);
    do_write(12'd5, 16'hFFFF, 2'b00);
    do_read(12'd5, "be zero", 16'hAB34, 1'b0, 16'h0);

    do_write(12'd3072, 16'h4142, 2'b11);
    do_read(12'd3072, "oor read", 16'h0000, 1'b0, 16'h0);
    do_read(12'd3071, "oor neighbour", 16'h0000, 1'b0, 16'h0);

    do_write(12'd10, 16'h1111, 2'b11);
    do_read(12'd10, "rbw old", 16'h1111, 1'b1, 16'h5555);
    do_read(12'd10, "rbw new", 16'h5555, 1'b0, 16'h0);

    @(negedge clk);
    clr_req = 1'b1; clr_data = 16'h0020;
    @(negedge clk);
    clr_req = 1'b0;
    count_busy(1, nb);
    cmp("sweep busy cycles", 32'(nb), 32'd3072);
    do_read(12'd7,    "fill7",    16'h0020, 1'b0, 16'h0);
    do_read(12'd0,    "fill0",    16'h0020, 1'b0, 16'h0);
    do_read(12'd3071, "fill3071", 16'h0020, 1'b0, 16'h0);
    cmp("model fill", 32'(mm[0][7]), 32'h00000020);

    @(negedge clk);
    clr_req = 1'b1; clr_data = 16'h0020;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (1536) @(negedge clk);
    do_reset;
    count_busy(0, nb);
    cmp("restart busy cycles", 32'(nb), 32'd3072);
    do_read(12'd7,    "restart7",    16'h0000, 1'b0, 16'h0);
    do_read(12'd3071, "restart3071", 16'h0000, 1'b0, 16'h0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                            : 12'($urandom_range(0, 31));
      wr_data = 16'($urandom);
      wr_be   = 2'($urandom_range(0, 3));
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                            : 12'($urandom_range(0, 31));
      clr_req  = ($urandom_range(0, 1999) == 0);
      clr_data = 16'($urandom);
      resetn   = !($urandom_range(0, 2999) == 0);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0; resetn = 1'b1;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
